// File: rtl/ram_fifo_ctrl.sv
// Pointer, occupancy and flag controller that runs a dual-port RAM as a
// synchronous FIFO of depth 2**AWIDTH; strobes are combinational, status is registered.
module ram_fifo_ctrl #(
  parameter int unsigned AWIDTH       = 3,
  parameter int unsigned ALMOST_FULL  = 6,
  parameter int unsigned ALMOST_EMPTY = 2
) (
  input  logic              clk_i,
  input  logic              aclr_n_i,
  input  logic              sclr_i,
  input  logic              wr_req_i,
  input  logic              rd_req_i,
  output logic              ram_wr_en_o,
  output logic              ram_rd_en_o,
  output logic [AWIDTH-1:0] wr_pntr_o,
  output logic [AWIDTH-1:0] rd_pntr_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] ONE   = {{AWIDTH{1'b0}}, 1'b1};

  logic [AWIDTH:0] wr_ptr, rd_ptr, usedw, usedw_next;
  logic            full, empty, almost_full, almost_empty, overflow, underflow;
  logic            wr_acc, rd_acc;

  // Acceptance looks only at registered flags, so a write into an empty FIFO
  // cannot be read back in the same cycle and full+read never admits a write.
  assign wr_acc = wr_req_i & ~full  & ~sclr_i;
  assign rd_acc = rd_req_i & ~empty & ~sclr_i;

  always_comb begin
    usedw_next = usedw;
    if (wr_acc && !rd_acc)
      usedw_next = usedw + ONE;
    else if (rd_acc && !wr_acc)
      usedw_next = usedw - ONE;
  end

  always_ff @(posedge clk_i or negedge aclr_n_i) begin
    if (!aclr_n_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (sclr_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      usedw        <= usedw_next;
      full         <= (usedw_next == DEPTH);
      empty        <= (usedw_next == '0);
      almost_full  <= (32'(usedw_next) >= ALMOST_FULL);
      almost_empty <= (32'(usedw_next) <  ALMOST_EMPTY);
      if (wr_req_i && full)  overflow  <= 1'b1;
      if (rd_req_i && empty) underflow <= 1'b1;
    end
  end

  assign ram_wr_en_o    = wr_acc;
  assign ram_rd_en_o    = rd_acc;
  assign wr_pntr_o      = wr_ptr[AWIDTH-1:0];
  assign rd_pntr_o      = rd_ptr[AWIDTH-1:0];
  assign full_o         = full;
  assign empty_o        = empty;
  assign usedw_o        = usedw;
  assign almost_full_o  = almost_full;
  assign almost_empty_o = almost_empty;
  assign overflow_o     = overflow;
  assign underflow_o    = underflow;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: a behavioural RAM sits beside the controller;
// stimulus queues expected status and data, a negedge monitor pops and compares.
module tb_ram_fifo_ctrl;

  logic       clk_i = 1'b0;
  logic       aclr_n_i, sclr_i, wr_req_i, rd_req_i;
  logic       ram_wr_en_o, ram_rd_en_o;
  logic [2:0] wr_pntr_o, rd_pntr_o;
  logic       full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o;
  logic [3:0] usedw_o;

  ram_fifo_ctrl #(.AWIDTH(3), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) dut (
    .clk_i(clk_i), .aclr_n_i(aclr_n_i), .sclr_i(sclr_i),
    .wr_req_i(wr_req_i), .rd_req_i(rd_req_i),
    .ram_wr_en_o(ram_wr_en_o), .ram_rd_en_o(ram_rd_en_o),
    .wr_pntr_o(wr_pntr_o), .rd_pntr_o(rd_pntr_o),
    .full_o(full_o), .empty_o(empty_o), .usedw_o(usedw_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Non-showahead RAM: data valid one cycle after the read strobe
  logic [7:0] mem [8];
  logic [7:0] din, ram_q;
  logic       rd_valid = 1'b0;
  always @(posedge clk_i) begin
    if (ram_wr_en_o) mem[wr_pntr_o] <= din;
    if (ram_rd_en_o) ram_q <= mem[rd_pntr_o];
    rd_valid <= ram_rd_en_o;
  end

  typedef struct {
    string       name;
    logic [18:0] v;
  } chk_t;

  chk_t       chk_q[$];
  logic [7:0] data_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cycles = 0;
  logic       done = 1'b0;

  // {usedw, wr_pntr, rd_pntr, wr_en, rd_en, full, empty, af, ae, ov, un}
  task automatic expect_now(input string n, input int uw, input int wp, input int rp,
                            input int we, input int re, input logic [5:0] fl);
    chk_t c;
    c.name = n;
    c.v = {4'(uw), 3'(wp), 3'(rp), 1'(we), 1'(re), fl};
    chk_q.push_back(c);
  endtask

  task automatic drive(input logic wr, input logic rd, input logic sc, input logic [7:0] d);
    wr_req_i = wr; rd_req_i = rd; sclr_i = sc; din = d;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    logic [18:0] act;
    logic [7:0]  exp_d;
    chk_t        c;
    cycles++;
    if (rd_valid && aclr_n_i) begin
      tests++;
      if (data_q.size() == 0) begin
        fails++;
        $display("FAIL data_order: got %02h, required no read data (queue empty)", ram_q);
      end else begin
        exp_d = data_q.pop_front();
        if (ram_q !== exp_d) begin
          fails++;
          $display("FAIL data_order: got %02h, required %02h", ram_q, exp_d);
        end
      end
    end
    act = {usedw_o, wr_pntr_o, rd_pntr_o, ram_wr_en_o, ram_rd_en_o,
           full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o};
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      tests++;
      if (act !== c.v) begin
        fails++;
        $display("FAIL %s: got usedw/wp/rp/we/re/flags=%b, required %b", c.name, act, c.v);
      end
    end
    if (done || cycles > 2000) begin
      if (!done) begin
        fails++;
        $display("FAIL timeout: stimulus did not finish within 2000 cycles");
      end
      tests++;
      if (data_q.size() != 0) begin
        fails++;
        $display("FAIL data_drained: got %0d entries left, required 0", data_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    aclr_n_i = 1'b0;
    drive(0, 0, 0, 8'h00);
    repeat (2) @(posedge clk_i);
    #1 aclr_n_i = 1'b1;

    drive(0, 0, 0, 8'h00);
    expect_now("reset_state", 0, 0, 0, 0, 0, 6'b010100);
    tick;

    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 8'(8'h10 + i));
      data_q.push_back(8'(8'h10 + i));
      expect_now("fill", i, i, 0, 1, 0, {1'b0, i == 0, i >= 6, i < 2, 2'b00});
      tick;
    end
    drive(1, 0, 0, 8'h99);
    expect_now("write_when_full", 8, 0, 0, 0, 0, 6'b101000);
    tick;
    drive(0, 0, 0, 8'h00);
    expect_now("overflow_set", 8, 0, 0, 0, 0, 6'b101010);
    tick;

    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 8'h00);
      expect_now("drain", 8 - i, 0, i, 0, 1, {i == 0, 1'b0, i <= 2, i == 7, 2'b10});
      tick;
    end
    drive(0, 1, 0, 8'h00);
    expect_now("read_when_empty", 0, 0, 0, 0, 0, 6'b010110);
    tick;
    drive(0, 0, 0, 8'h00);
    expect_now("underflow_set", 0, 0, 0, 0, 0, 6'b010111);
    tick;
    drive(0, 0, 1, 8'h00);
    expect_now("sclr_cycle_idle", 0, 0, 0, 0, 0, 6'b010111);
    tick;
    drive(0, 0, 0, 8'h00);
    expect_now("sclr_clears_errs", 0, 0, 0, 0, 0, 6'b010100);
    tick;

    drive(1, 1, 0, 8'h20);
    data_q.push_back(8'h20);
    expect_now("empty_wr_rd", 0, 0, 0, 1, 0, 6'b010100);
    tick;
    drive(0, 1, 0, 8'h00);
    expect_now("empty_wr_rd_after", 1, 1, 0, 0, 1, 6'b000101);
    tick;
    drive(0, 0, 1, 8'h00);
    expect_now("sclr_after_one", 0, 1, 1, 0, 0, 6'b010101);
    tick;

    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 8'(8'h30 + i));
      data_q.push_back(8'(8'h30 + i));
      tick;
    end
    drive(1, 1, 0, 8'h99);
    expect_now("full_wr_rd", 8, 0, 0, 0, 1, 6'b101000);
    tick;
    drive(0, 0, 0, 8'h00);
    expect_now("full_wr_rd_after", 7, 0, 1, 0, 0, 6'b001010);
    tick;

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 8'h00);
      tick;
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 8'(8'h40 + i));
      data_q.push_back(8'(8'h40 + i));
      expect_now("steady_wr_rd", 4, i % 8, (4 + i) % 8, 1, 1, 6'b000010);
      tick;
    end
    drive(0, 0, 0, 8'h00);
    expect_now("after_wrap", 4, 2, 6, 0, 0, 6'b000010);
    tick;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 8'h00);
      tick;
    end
    drive(0, 0, 0, 8'h00);
    expect_now("wrap_drained", 0, 2, 2, 0, 0, 6'b010110);
    tick;

    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 8'(8'h50 + i));
      tick;
    end
    drive(1, 0, 1, 8'h77);
    expect_now("sclr_over_write", 5, 7, 2, 0, 0, 6'b000010);
    tick;
    drive(0, 0, 0, 8'h00);
    expect_now("sclr_result", 0, 0, 0, 0, 0, 6'b010100);
    tick;

    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 8'h60);
      tick;
    end
    drive(0, 0, 0, 8'h00);
    aclr_n_i = 1'b0;
    #1;
    expect_now("async_reset", 0, 0, 0, 0, 0, 6'b010100);
    @(negedge clk_i);
    #1 aclr_n_i = 1'b1;
    tick;
    tick;
    done = 1'b1;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Single-clock pointer/flag controller that sequences the team's dual-port RAM macro as a synchronous FIFO of depth 2**AWIDTH.
- Accepts write/read requests from the user side.
- Generates the RAM's write enable, read enable, write and read pointers, and full/empty qualifiers.
- Keeps occupancy, almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Instantiated beside the RAM, with both RAM clocks tied to clk_i.

Parameters:
AWIDTH, 3, RAM address width; FIFO depth = 2**AWIDTH.
ALMOST_FULL, 6, almost_full_o asserts when usedw_o >= ALMOST_FULL (legal 1..2**AWIDTH).
ALMOST_EMPTY, 2, almost_empty_o asserts when usedw_o < ALMOST_EMPTY (legal 1..2**AWIDTH).

Ports:
clk_i  input  1  single clock for controller and RAM
aclr_n_i  input  1  asynchronous active-low reset
sclr_i  input  1  synchronous clear, active high
wr_req_i  input  1  user write request
rd_req_i  input  1  user read request
ram_wr_en_o  output  1  RAM write strobe (accepted write), combinational
ram_rd_en_o  output  1  RAM read strobe (accepted read), combinational
wr_pntr_o  output  AWIDTH  RAM write address
rd_pntr_o  output  AWIDTH  RAM read address
full_o  output  1  FIFO full, registered
empty_o  output  1  FIFO empty, registered
usedw_o  output  AWIDTH+1  occupancy 0..2**AWIDTH, registered
almost_full_o  output  1  threshold flag, registered
almost_empty_o  output  1  threshold flag, registered
overflow_o  output  1  sticky: write requested while full
underflow_o  output  1  sticky: read requested while empty

Behaviour:
- Reset is asserted asynchronously when aclr_n_i is low and released synchronously to clk_i.
- Reset values:
  - pointers 0, usedw_o 0
  - empty_o 1, full_o 0
  - almost_empty_o 1, almost_full_o 0
  - overflow_o 0, underflow_o 0
- sclr_i high at a rising edge restores the same reset values on that edge. It overrides any request in that cycle; both RAM strobes are forced 0.
- Internal pointers are AWIDTH+1 bits. wr_pntr_o and rd_pntr_o are the low AWIDTH bits. The MSB toggles on wrap.
- Write acceptance: ram_wr_en_o = wr_req_i & !full_o & !sclr_i. Each accepted write increments the write pointer at the edge.
- Read acceptance: ram_rd_en_o = rd_req_i & !empty_o & !sclr_i. Each accepted read increments the read pointer at the edge.
- Acceptance uses only registered flags. There is no same-cycle write-through.
  - Full plus simultaneous write and read: read accepted, write rejected; usedw goes 2**AWIDTH to 2**AWIDTH-1.
  - Empty plus simultaneous write and read: write accepted, read rejected; usedw goes 0 to 1.
  - Both accepted: pointers both advance, usedw unchanged, flags unchanged.
- usedw next value = usedw + accepted write - accepted read.
- All flags are computed from the next-state usedw and registered on the same edge as the pointers, so they are valid in the cycle after the accepting edge.
  - full_o = (usedw == 2**AWIDTH), equivalent to pointer MSBs differing with equal low bits.
  - empty_o = (usedw == 0).
  - almost_full_o = (usedw >= ALMOST_FULL).
  - almost_empty_o = (usedw < ALMOST_EMPTY).
- overflow_o sets on any edge where wr_req_i & full_o and the write is rejected. underflow_o sets on any edge where rd_req_i & empty_o. Both hold until reset or sclr_i.
- A rejected request changes no pointer and no usedw.
- Pointer wrap: the low AWIDTH bits go from 2**AWIDTH-1 to 0 with the MSB toggled. Ordering across the wrap must be preserved.
- RAM read latency belongs to the RAM. In non-showahead mode, data appears on the RAM output 1 cycle after ram_rd_en_o. The controller adds no latency.
- Reset or sclr mid-operation discards contents; RAM contents are not cleared.

Test Plan:
- Reset (AWIDTH=3): pulse aclr_n_i low mid-cycle -> outputs take reset values immediately, without waiting for a clock edge; empty_o=1, almost_empty_o=1, usedw_o=0.
- Fill: 8 consecutive writes of 0x10..0x17 -> wr_pntr_o steps 0..7 then 0; usedw_o=8; full_o=1 after the 8th edge; almost_full_o=1 after the 6th edge; a 9th write -> ram_wr_en_o=0, overflow_o=1, usedw_o stays 8.
- Drain: 8 reads -> ram_rd_en_o pulses with rd_pntr_o 0..7; RAM returns 0x10..0x17 in order; empty_o=1 after the 8th edge; almost_empty_o=1 once usedw_o<2; an extra read -> underflow_o=1.
- Simultaneous at boundaries: from empty, wr+rd -> only the write accepted, usedw_o=1. From full, wr+rd -> only the read accepted, usedw_o=7. At usedw 4, wr+rd for 10 cycles -> usedw_o stays 4, both pointers wrap, data order is preserved.
- sclr_i: at usedw 5 with wr_req_i=1, assert sclr_i for one cycle -> usedw_o=0, empty_o=1, pointers 0, overflow_o/underflow_o cleared, ram_wr_en_o=0 that cycle.
